// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI memory engine between instruction fetch (ROM)
// and data (RAM) requesters, with a watchdog that aborts a hung transfer.
module spi_mem_arbiter #(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [15:0] fetch_addr,
   output logic        fetch_ack,
   output logic [7:0]  fetch_rdata,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [15:0] mem_addr,
   input  logic [7:0]  mem_wdata,
   output logic        mem_ack,
   output logic [7:0]  mem_rdata,
   output logic        spi_start,
   output logic        spi_write,
   output logic [15:0] spi_address,
   output logic [7:0]  spi_wdata,
   input  logic [7:0]  spi_rdata,
   input  logic        spi_done,
   output logic        sel_rom,
   output logic        sel_ram,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   typedef enum logic {OWN_FETCH, OWN_MEM} owner_t;

   state_t           state_q;
   owner_t           owner_q;
   owner_t           last_grant_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fetch_ack_q;
   logic             mem_ack_q;
   logic [7:0]       fetch_rdata_q;
   logic [7:0]       mem_rdata_q;
   logic             spi_start_q;
   logic             spi_write_q;
   logic [15:0]      spi_address_q;
   logic [7:0]       spi_wdata_q;
   logic             sel_rom_q;
   logic             sel_ram_q;
   logic             busy_q;
   logic             timeout_err_q;

   logic             grant_d;
   owner_t           grant_owner_d;
   logic             timeout_hit_d;
   logic [7:0]       xfer_rdata_d;

   always_comb begin
      grant_d = fetch_req | mem_req;
      // On contention the requester that did not win last time gets the engine.
      if (fetch_req && mem_req)
         grant_owner_d = (last_grant_q == OWN_MEM) ? OWN_FETCH : OWN_MEM;
      else
         grant_owner_d = fetch_req ? OWN_FETCH : OWN_MEM;
      timeout_hit_d = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
      if (spi_done)
         xfer_rdata_d = spi_write_q ? 8'h00 : spi_rdata;
      else
         xfer_rdata_d = 8'hFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         owner_q       <= OWN_FETCH;
         last_grant_q  <= OWN_MEM;
         cnt_q         <= '0;
         fetch_ack_q   <= 1'b0;
         mem_ack_q     <= 1'b0;
         fetch_rdata_q <= '0;
         mem_rdata_q   <= '0;
         spi_start_q   <= 1'b0;
         spi_write_q   <= 1'b0;
         spi_address_q <= '0;
         spi_wdata_q   <= '0;
         sel_rom_q     <= 1'b0;
         sel_ram_q     <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         fetch_ack_q <= 1'b0;
         mem_ack_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_d) begin
                  owner_q       <= grant_owner_d;
                  last_grant_q  <= grant_owner_d;
                  spi_address_q <= (grant_owner_d == OWN_FETCH) ? fetch_addr : mem_addr;
                  spi_write_q   <= (grant_owner_d == OWN_MEM) && mem_we;
                  spi_wdata_q   <= (grant_owner_d == OWN_MEM) ? mem_wdata : '0;
                  cnt_q         <= '0;
                  spi_start_q   <= 1'b1;
                  sel_rom_q     <= (grant_owner_d == OWN_FETCH);
                  sel_ram_q     <= (grant_owner_d == OWN_MEM);
                  busy_q        <= 1'b1;
                  state_q       <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (spi_done || timeout_hit_d) begin
                  if (!spi_done)
                     timeout_err_q <= 1'b1;
                  spi_start_q <= 1'b0;
                  sel_rom_q   <= 1'b0;
                  sel_ram_q   <= 1'b0;
                  if (owner_q == OWN_FETCH) begin
                     fetch_ack_q   <= 1'b1;
                     fetch_rdata_q <= xfer_rdata_d;
                  end else begin
                     mem_ack_q   <= 1'b1;
                     mem_rdata_q <= xfer_rdata_d;
                  end
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign fetch_ack   = fetch_ack_q;
   assign fetch_rdata = fetch_rdata_q;
   assign mem_ack     = mem_ack_q;
   assign mem_rdata   = mem_rdata_q;
   assign spi_start   = spi_start_q;
   assign spi_write   = spi_write_q;
   assign spi_address = spi_address_q;
   assign spi_wdata   = spi_wdata_q;
   assign sel_rom     = sel_rom_q;
   assign sel_ram     = sel_ram_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Shares the single SPI memory engine between two requesters: the instruction-fetch port (ROM chip, read-only, PC-addressed) and the data port (RAM chip, read/write, {mpage, mar}-addressed).
- Sits between the CU/datapath and the spi module.
- Owns the spi start/done handshake, selects which chip-select path is active, and returns read data with a one-cycle ack pulse.
- Adds fair round-robin arbitration and a watchdog timeout, so a hung transfer cannot stall the CPU forever.

Parameters:
- TIMEOUT, 1024: maximum BUSY cycles before a transfer is aborted. 0 disables the watchdog.
- CNT_W, 11: watchdog counter width. Must hold TIMEOUT.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- fetch_req  input  1  fetch request; level, held until fetch_ack
- fetch_addr  input  16  fetch byte address (PC)
- fetch_ack  output  1  one-cycle pulse; fetch_rdata valid this cycle
- fetch_rdata  output  8  fetched byte
- mem_req  input  1  data request; level, held until mem_ack
- mem_we  input  1  1 = write, 0 = read
- mem_addr  input  16  data address {mpage, mar}
- mem_wdata  input  8  write byte
- mem_ack  output  1  one-cycle pulse; mem_rdata valid this cycle
- mem_rdata  output  8  read byte (0x00 on writes)
- spi_start  output  1  level start to spi engine
- spi_write  output  1  write qualifier to spi engine
- spi_address  output  16  latched transfer address
- spi_wdata  output  8  latched write byte
- spi_rdata  input  8  spi engine read data
- spi_done  input  1  spi engine completion
- sel_rom  output  1  ROM chip-select path enabled
- sel_ram  output  1  RAM chip-select path enabled
- busy  output  1  arbiter not IDLE
- timeout_err  output  1  sticky watchdog abort flag

Behaviour:
- All outputs are registered.
- Reset (synchronous, any state, including mid-transfer) forces:
  - state IDLE, all outputs 0, watchdog count 0;
  - last_grant = MEM, so fetch wins the first contention.
  - The spi engine sees spi_start drop on the next edge.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If only one req is high, grant it. If both are high, grant the one not equal to last_grant.
  - On grant: latch owner, address, write flag (fetch always 0) and wdata; set last_grant = owner; clear count; go to BUSY.
  - spi_done in IDLE is ignored.
- BUSY:
  - spi_start = 1. sel_rom = (owner == FETCH), sel_ram = (owner == MEM); exactly one is high.
  - spi_address, spi_write and spi_wdata are stable from the latch and do not follow live inputs.
  - If spi_done = 1: capture spi_rdata (0x00 if write), go to DONE.
  - Else if TIMEOUT != 0 and count == TIMEOUT-1: set timeout_err = 1, rdata = 0xFF, go to DONE.
  - Else increment count.
- DONE:
  - spi_start = 0, sel_* = 0.
  - Owner's ack = 1 for exactly one cycle, with rdata valid. The non-owner's ack stays 0.
  - Go to IDLE.
- Latency:
  - req high in IDLE at cycle N gives spi_start high at N+1.
  - spi_done high at cycle D gives ack at D+1 and IDLE at D+2.
- Requester rule: deassert req on the same edge that samples ack, i.e. req low from D+2. A req still high at D+2 is treated as a new request.
- Rdata outputs hold their last value between acks. Acks are never asserted simultaneously.
- timeout_err is cleared only by rst.
- busy = (state != IDLE).
- Live changes to req inputs or addresses while BUSY/DONE have no effect on the current transfer.

Test Plan:
- Single fetch: fetch_req=1, fetch_addr=0x0123; spi_done after 20 cycles with spi_rdata=0xA5 -> spi_start high from the next cycle with spi_address=0x0123, sel_rom=1, spi_write=0; fetch_ack pulse one cycle after done with fetch_rdata=0xA5.
- Data write: mem_req=1, mem_we=1, mem_addr=0x0210, mem_wdata=0x3C -> spi_write=1, spi_wdata=0x3C, sel_ram=1; mem_ack pulse with mem_rdata=0x00; fetch_ack stays 0.
- Contention after reset: fetch_req and mem_req high together, both held -> grant order FETCH, MEM, FETCH, MEM over four transfers. Each grant starts exactly one cycle after the previous ack's following IDLE cycle.
- Address stability: change mem_addr from 0x0210 to 0xFFFF while BUSY -> spi_address stays 0x0210 until DONE.
- Watchdog: TIMEOUT=8, spi_done never asserted -> after 8 BUSY cycles, timeout_err=1, ack with rdata=0xFF, return to IDLE. timeout_err stays 1 until rst.
- Reset mid-transfer: assert rst during BUSY -> next cycle spi_start=0, busy=0, sel_*=0, no ack. A subsequent simultaneous request grants FETCH first.
